// File: rtl/hex_keypad_scanner.sv
// rtl/hex_keypad_scanner.sv - 4x4 hex keypad column scanner with frame-based press/release debounce
module hex_keypad_scanner #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] col_n,
  input  logic [3:0] row_n,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LIM  = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_t;
  typedef enum logic [1:0] {F_NONE, F_SINGLE, F_MULTI} fclass_t;

  logic [3:0]       row_s1, row_s2;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       col_idx;
  logic [1:0]       hit_cnt;
  logic [3:0]       hit_code;
  state_t           state, state_n;
  logic [3:0]       cand, cand_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       key_n;
  logic             valid_n, held_n;

  logic             sample, frame_end;
  logic [2:0]       col_hits, sum;
  logic [3:0]       col_code, frame_code;
  fclass_t          cls;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: return 4'h1;  4'h1: return 4'h2;  4'h2: return 4'h3;  4'h3: return 4'hA;
      4'h4: return 4'h4;  4'h5: return 4'h5;  4'h6: return 4'h6;  4'h7: return 4'hB;
      4'h8: return 4'h7;  4'h9: return 4'h8;  4'hA: return 4'h9;  4'hB: return 4'hC;
      4'hC: return 4'hE;  4'hD: return 4'h0;  4'hE: return 4'hF;  default: return 4'hD;
    endcase
  endfunction

  assign sample    = (div_cnt == DIV_LAST);
  assign frame_end = sample && (col_idx == 2'd3);
  assign col_n     = ~(4'b0001 << col_idx);

  // Two-flop synchroniser for the asynchronous row inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1 <= 4'b1111;
      row_s2 <= 4'b1111;
    end else begin
      row_s1 <= row_n;
      row_s2 <= row_s1;
    end
  end

  // Column timing: hold each column for SCAN_DIV cycles, then advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      col_idx <= 2'd0;
    end else if (sample) begin
      div_cnt <= '0;
      col_idx <= col_idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Contacts in the current column plus the running total for this frame.
  always_comb begin
    col_hits = 3'd0;
    col_code = 4'h0;
    for (int r = 0; r < 4; r++) begin
      if (!row_s2[r]) begin
        col_hits = col_hits + 3'd1;
        col_code = key_map(2'(r), col_idx);
      end
    end
    sum        = {1'b0, hit_cnt} + col_hits;
    frame_code = (hit_cnt != 2'd0) ? hit_code : col_code;
    if (sum == 3'd0)      cls = F_NONE;
    else if (sum == 3'd1) cls = F_SINGLE;
    else                  cls = F_MULTI;
  end

  // Frame accumulator: saturating contact count (0, 1, 2+) and first code seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= 2'd0;
      hit_code <= 4'h0;
    end else if (frame_end) begin
      hit_cnt  <= 2'd0;
      hit_code <= 4'h0;
    end else if (sample) begin
      hit_cnt  <= (sum > 3'd1) ? 2'd2 : sum[1:0];
      hit_code <= frame_code;
    end
  end

  // Debounce state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cand      <= 4'h0;
      cnt       <= '0;
      key       <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_n;
      cand      <= cand_n;
      cnt       <= cnt_n;
      key       <= key_n;
      key_valid <= valid_n;
      key_held  <= held_n;
    end
  end

  // Debounce decisions, taken once per frame on its final sample.
  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    key_n   = key;
    held_n  = key_held;
    valid_n = 1'b0;
    if (frame_end) begin
      case (state)
        S_IDLE: begin
          if (cls == F_SINGLE) begin
            cand_n = frame_code;
            if (CNT_LIM == CNT_ONE) begin
              key_n   = frame_code;
              valid_n = 1'b1;
              held_n  = 1'b1;
              cnt_n   = '0;
              state_n = S_PRESSED;
            end else begin
              cnt_n   = CNT_ONE;
              state_n = S_DEBOUNCE;
            end
          end
        end
        S_DEBOUNCE: begin
          if (cls == F_SINGLE && frame_code == cand) begin
            cnt_n = cnt + CNT_ONE;
            if (cnt_n == CNT_LIM) begin
              key_n   = cand;
              valid_n = 1'b1;
              held_n  = 1'b1;
              cnt_n   = '0;
              state_n = S_PRESSED;
            end
          end else if (cls == F_SINGLE) begin
            cand_n = frame_code;
            cnt_n  = CNT_ONE;
          end else begin
            cnt_n   = '0;
            state_n = S_IDLE;
          end
        end
        S_PRESSED: begin
          if (cls == F_NONE) begin
            if (CNT_LIM == CNT_ONE) begin
              held_n  = 1'b0;
              cnt_n   = '0;
              state_n = S_IDLE;
            end else begin
              cnt_n   = CNT_ONE;
              state_n = S_RELEASE;
            end
          end
        end
        S_RELEASE: begin
          if (cls == F_NONE) begin
            cnt_n = cnt + CNT_ONE;
            if (cnt_n == CNT_LIM) begin
              held_n  = 1'b0;
              cnt_n   = '0;
              state_n = S_IDLE;
            end
          end else begin
            cnt_n   = '0;
            state_n = S_PRESSED;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// tb/tb_hex_keypad_scanner.sv - self-checking bench for hex_keypad_scanner
module tb_hex_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  col_n, row_n, key;
  logic        key_valid, key_held;
  logic [15:0] pressed = 16'h0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hex_keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clk(clk), .rst_n(rst_n), .col_n(col_n), .row_n(row_n),
    .key(key), .key_valid(key_valid), .key_held(key_held)
  );

  // Keypad matrix: a pressed key at (r,c) pulls row r low while column c is driven.
  always_comb begin
    row_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  // Key legend, index r*4+c.
  logic [3:0] key_tbl [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                               4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC,
                               4'hE, 4'h0, 4'hF, 4'hD};

  int          k;
  int          fi;
  logic [15:0] frame_mask [0:127];
  int          hist[$];
  logic        m_held = 1'b0;
  logic [3:0]  m_key = 4'h0;
  logic        running = 1'b0;
  int          n_pulse = 0;
  int          last_pulse_k = -1;
  logic [3:0]  last_pulse_key = 4'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t k=%0d)", name, act, exp, $time, k);
    end
  endtask

  // -1 = no contact, -2 = several contacts, otherwise the single key code.
  function automatic int classify(input logic [15:0] m);
    int n = 0;
    int code = 0;
    for (int i = 0; i < 16; i++)
      if (m[i]) begin
        n++;
        code = int'(key_tbl[i]);
      end
    if (n == 0) return -1;
    if (n > 1) return -2;
    return code;
  endfunction

  // Acceptance: three latest frames the same single key while not held.
  // Release: three latest frames empty while held.
  task automatic model_step(input int m, output logic pulse);
    int n;
    pulse = 1'b0;
    hist.push_back(classify(frame_mask[m]));
    n = hist.size();
    if (n >= 3) begin
      if (!m_held && hist[n-1] >= 0 && hist[n-1] == hist[n-2] && hist[n-2] == hist[n-3]) begin
        pulse  = 1'b1;
        m_held = 1'b1;
        m_key  = 4'(hist[n-1]);
      end else if (m_held && hist[n-1] == -1 && hist[n-2] == -1 && hist[n-3] == -1) begin
        m_held = 1'b0;
      end
    end
  endtask

  // Cycles since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    logic       pulse;
    logic [3:0] exp_col;
    if (rst_n && running) begin
      pulse = 1'b0;
      if (k > 0 && k % 16 == 0) model_step(k / 16, pulse);
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      check("col_n", {28'd0, col_n}, {28'd0, exp_col});
      check("key", {28'd0, key}, {28'd0, m_key});
      check("key_valid", {31'd0, key_valid}, {31'd0, pulse});
      check("key_held", {31'd0, key_held}, {31'd0, m_held});
      case (k)
        4:  check("col_seq_4", {28'd0, col_n}, 32'hD);
        8:  check("col_seq_8", {28'd0, col_n}, 32'hB);
        12: check("col_seq_12", {28'd0, col_n}, 32'h7);
        16: check("col_seq_16", {28'd0, col_n}, 32'hE);
        default: ;
      endcase
      if (key_valid) begin
        n_pulse++;
        last_pulse_k   = k;
        last_pulse_key = key;
      end
    end
  end

  task automatic run_frames(input logic [15:0] mask, input int n);
    for (int i = 0; i < n; i++) begin
      pressed = mask;
      fi++;
      frame_mask[fi] = mask;
      repeat (16) @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check_outputs_clear(input string tag);
    check({tag, "_col_n"}, {28'd0, col_n}, 32'hE);
    check({tag, "_key"}, {28'd0, key}, 32'h0);
    check({tag, "_key_valid"}, {31'd0, key_valid}, 32'h0);
    check({tag, "_key_held"}, {31'd0, key_held}, 32'h0);
  endtask

  initial begin
    fi = 0;
    repeat (3) @(negedge clk);
    check_outputs_clear("in_reset");
    #1 rst_n = 1'b1;
    running = 1'b1;
    check_outputs_clear("post_reset");

    // Key 5 held for 13 frames: one strobe at the end of frame 3.
    run_frames(16'h0020, 13);
    check("s2_pulses", n_pulse, 1);
    check("s2_key", {28'd0, last_pulse_key}, 32'h5);
    check("s2_pulse_k", last_pulse_k, 48);
    check("s2_held", {31'd0, key_held}, 32'h1);

    // Release, then a too-short press of 0.
    run_frames(16'h0000, 3);
    check("s4_held", {31'd0, key_held}, 32'h0);
    check("s4_key", {28'd0, key}, 32'h5);
    run_frames(16'h2000, 2);
    run_frames(16'h0000, 2);
    check("s4_pulses", n_pulse, 1);

    // Bouncing 9, then stable: strobe at the end of frame 27.
    run_frames(16'h0400, 1);
    run_frames(16'h0000, 1);
    run_frames(16'h0400, 1);
    run_frames(16'h0000, 1);
    run_frames(16'h0400, 4);
    check("s3_pulses", n_pulse, 2);
    check("s3_key", {28'd0, last_pulse_key}, 32'h9);
    check("s3_pulse_k", last_pulse_k, 432);
    run_frames(16'h0000, 4);

    // 1 and 2 together: never accepted.
    run_frames(16'h0003, 6);
    check("s5_pulses", n_pulse, 2);
    check("s5_held", {31'd0, key_held}, 32'h0);
    run_frames(16'h0000, 2);

    // D accepted, then reset mid-frame with D still down.
    run_frames(16'h8000, 4);
    check("s6_pulses", n_pulse, 3);
    check("s6_pulse_k", last_pulse_k, 688);
    check("s6_held", {31'd0, key_held}, 32'h1);
    check("s6_key", {28'd0, key}, 32'hD);
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    running = 1'b0;
    #1 check_outputs_clear("async_reset");
    hist.delete();
    m_held = 1'b0;
    m_key  = 4'h0;
    fi = 0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    running = 1'b1;
    run_frames(16'h8000, 4);
    check("s6b_pulses", n_pulse, 4);
    check("s6b_key", {28'd0, last_pulse_key}, 32'hD);
    check("s6b_pulse_k", last_pulse_k, 48);
    check("s6b_held", {31'd0, key_held}, 32'h1);

    running = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
